vector_lane_sequencer: RTL
==========================

# vector_lane_sequencer

Sequencer that drives the scalar/vector lane router to move data between the 32-bit scalar domain and the 128-bit vector domain. A pack command collects 1–4 scalars over a valid/ready stream and inserts them into lanes 0..N-1 of a zeroed vector, emitting the finished vector. An unpack command takes a 128-bit vector and emits lanes 0..N-1 as a scalar stream. The router stays an external combinational instance; this block owns its `rerouting_code`, `scalar` and `vector_in` inputs and consumes its `vector_out`.

## Interface
- No parameters. Lane width is fixed at 32 bits, with 4 lanes.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort. Returns the block to IDLE and discards the partial result.
- `cmd_valid` / `cmd_ready` in/out 1: command handshake.
- `cmd_op` in 1: 0 = pack, 1 = unpack.
- `cmd_len` in 2: lane count minus 1 (0 → 1 lane, 3 → 4 lanes).
- `cmd_vector` in 128: unpack source vector. Ignored for pack.
- `sin_valid` / `sin_ready` in/out 1: pack scalar input handshake.
- `sin_data` in 32: scalar to insert.
- `vout_valid` / `vout_ready` out/in 1: packed vector output handshake.
- `vout_data` out 128: packed vector.
- `sout_valid` / `sout_ready` out/in 1: unpacked scalar output handshake.
- `sout_data` out 32: extracted lane.
- `rt_code` out 3: router rerouting code.
- `rt_scalar` out 32: router scalar input.
- `rt_vector_in` out 128: router vector input.
- `rt_vector_out` in 128: router result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Registers:
  - `state` ∈ {IDLE, PACK, PACK_DONE, UNPACK}
  - `vec_q[127:0]`
  - `lane_q[1:0]`
  - `len_q[1:0]`
- Router codes used:
  - Codes 0–3 insert `rt_scalar` into lane k = code. All other lanes pass through.
  - Codes 4–7 copy lane (code-4) into lane 0. Upper lanes pass through.
- **IDLE**
  - `cmd_ready = !flush`.
  - On `cmd_valid && cmd_ready`: `len_q <= cmd_len`, `lane_q <= 0`.
  - Pack: `vec_q <= 0`, next state PACK.
  - Unpack: `vec_q <= cmd_vector`, next state UNPACK.
- **PACK**
  - `sin_ready = 1`, `rt_code = {1'b0, lane_q}`, `rt_scalar = sin_data`, `rt_vector_in = vec_q`.
  - On each `sin` handshake: `vec_q <= rt_vector_out`.
  - If `lane_q == len_q`, go to PACK_DONE. Otherwise `lane_q++`.
- **PACK_DONE**
  - `vout_valid = 1`, `vout_data = vec_q`.
  - On `vout_ready`, return to IDLE.
  - Lanes above `len_q` remain 0.
- **UNPACK**
  - `sout_valid = 1`, `rt_code = {1'b1, lane_q}`, `rt_vector_in = vec_q`, `sout_data = rt_vector_out[31:0]`.
  - On each `sout` handshake: if `lane_q == len_q`, go to IDLE. Otherwise `lane_q++`.
  - `vec_q` is not modified.
- **Router defaults:** outside PACK/UNPACK, `rt_code = 0`, `rt_scalar = 0`, `rt_vector_in = vec_q`.
- **Handshakes:**
  - A transfer occurs on a cycle where valid && ready at the clock edge.
  - Valid outputs never drop, and their data never changes, until the transfer occurs.
  - `sin_ready`, `cmd_ready`, `vout_valid` and `sout_valid` are functions of registered state only, plus `flush` for `cmd_ready`. They have no combinational path from the partner's valid/ready.
- **flush:** highest priority. In any state it forces next state IDLE, `lane_q <= 0` and `vec_q <= 0`. Any handshake coinciding with `flush` is dropped:
  - A scalar accepted that cycle is discarded.
  - A presented vector or scalar is not considered delivered.
  - A command is not accepted.
- **Reset values:**
  - State IDLE, `vec_q = 0`, `lane_q = 0`, `len_q = 0`.
  - `cmd_ready = 1`; `sin_ready`, `vout_valid`, `sout_valid`, `busy` = 0.
  - `rt_code = 0`, `rt_scalar = 0`, `rt_vector_in = 0`, `vout_data = 0`.

## Timing
- Command accepted at edge t. Then `busy`, and `sin_ready` or `sout_valid`, are high from cycle t+1.
- **Pack of N lanes** with `sin_valid` held high: scalar handshakes in cycles t+1..t+N, `vout_valid` in cycle t+N+1. Minimum throughput is one lane per cycle.
- **Unpack of N lanes** with `sout_ready` held high: scalars in cycles t+1..t+N, IDLE (`cmd_ready = 1`) in cycle t+N+1.
- **Back-to-back:**
  - After the final `vout` or `sout` handshake, the next command can be accepted in the following cycle.
  - No command is accepted in the same cycle as a completing handshake.
- Reset mid-operation takes effect immediately (asynchronously). Outputs show reset values while `rst_n` is low.

## Test plan
- **Reset:** assert `rst_n = 0` mid-PACK → `busy = 0`, `cmd_ready = 1`, `vout_valid = 0`. A following pack starts from lane 0 with a zero vector.
- **Pack, 4 lanes, continuous:** `cmd_op = 0`, `cmd_len = 3`, scalars 0x11, 0x22, 0x33, 0x44 → `vout_data = 0x00000044_00000033_00000022_00000011`, `vout_valid` exactly 5 cycles after command accept.
- **Pack, 2 lanes, with stalls:** `cmd_len = 1`, `sin_valid` gapped, scalars 0xAAAA5555, 0xDEADBEEF, then `vout_ready` held low 3 cycles → `vout_data = 0x00000000_00000000_DEADBEEF_AAAA5555`, stable through the stall.
- **Unpack, 4 lanes:** `cmd_vector = 0x44444444_33333333_22222222_11111111`, `sout_ready` toggling each cycle → `sout_data` sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444. Each value held while unacked. `rt_code` = 4, 5, 6, 7.
- **Unpack, 1 lane, then back-to-back pack:** `cmd_len = 0` → a single `sout` of lane 0, `cmd_ready = 1` on the next cycle. The pack command is accepted that cycle.
- **Flush:** `flush` pulsed after 2 of 4 pack scalars, coincident with a `sin` handshake → IDLE next cycle, no `vout_valid`. A subsequent 1-lane pack of 0x7 yields `vout_data = 0x7`.

Source files
------------

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: moves data between the 32-bit scalar domain and the
// 128-bit vector domain by steering an external combinational lane router.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   S_IDLE       | waiting for a command; cmd_ready high unless flushing
//   S_PACK       | inserting incoming scalars into lanes 0..len of r_vec
//   S_PACK_DONE  | presenting the finished vector until vout handshake
//   S_UNPACK     | emitting lanes 0..len of r_vec as a scalar stream
module vector_lane_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [1:0]   cmd_len,
  input  logic [127:0] cmd_vector,
  input  logic         sin_valid,
  output logic         sin_ready,
  input  logic [31:0]  sin_data,
  output logic         vout_valid,
  input  logic         vout_ready,
  output logic [127:0] vout_data,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic [31:0]  sout_data,
  output logic [2:0]   rt_code,
  output logic [31:0]  rt_scalar,
  output logic [127:0] rt_vector_in,
  input  logic [127:0] rt_vector_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PACK      = 2'd1,
    S_PACK_DONE = 2'd2,
    S_UNPACK    = 2'd3
  } state_t;

  state_t       r_state;
  logic [127:0] r_vec;
  logic [1:0]   r_lane;
  logic [1:0]   r_len;

  logic w_last_lane;
  assign w_last_lane = (r_lane == r_len);

  // Sequencer state, working vector and lane counters; flush overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_lane  <= '0;
      r_len   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_lane  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_len  <= cmd_len;
            r_lane <= '0;
            if (cmd_op) begin
              r_vec   <= cmd_vector;
              r_state <= S_UNPACK;
            end else begin
              r_vec   <= '0;
              r_state <= S_PACK;
            end
          end
        end
        S_PACK: begin
          if (sin_valid) begin
            r_vec <= rt_vector_out;
            if (w_last_lane) r_state <= S_PACK_DONE;
            else             r_lane  <= r_lane + 2'd1;
          end
        end
        S_PACK_DONE: begin
          if (vout_ready) r_state <= S_IDLE;
        end
        S_UNPACK: begin
          if (sout_ready) begin
            if (w_last_lane) r_state <= S_IDLE;
            else             r_lane  <= r_lane + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake and router steering decoded from registered state only
  // (flush gates cmd_ready); data paths pass straight through the router.
  always_comb begin
    cmd_ready  = 1'b0;
    sin_ready  = 1'b0;
    vout_valid = 1'b0;
    vout_data  = '0;
    sout_valid = 1'b0;
    sout_data  = '0;
    rt_code    = 3'd0;
    rt_scalar  = '0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: cmd_ready = !flush;
      S_PACK: begin
        sin_ready = 1'b1;
        rt_code   = {1'b0, r_lane};
        rt_scalar = sin_data;
      end
      S_PACK_DONE: begin
        vout_valid = 1'b1;
        vout_data  = r_vec;
      end
      S_UNPACK: begin
        sout_valid = 1'b1;
        rt_code    = {1'b1, r_lane};
        sout_data  = rt_vector_out[31:0];
      end
      default: ;
    endcase
  end

  // The router always works on the held vector.
  assign rt_vector_in = r_vec;

endmodule
